dm_arbiter: RTL and testbench

Single-port data-memory arbiter that shares the `dm` instance between the processor core's load/store path and a memory loader/dump engine used by the bench between programs. Each cycle it grants at most one requester, drives the memory port from the winner and registers read data back with an owner tag. Round-robin fairness and a bounded loader burst lock keep the core from starving.

---
 rtl/dm_arbiter.sv | 144 ++++++++++++++
 tb/tb_dm_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter between the core load/store path and the loader.
// Round-robin sharing, plus a loader burst lock that is force-released after MAXBURST cycles.
module dm_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAXBURST = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_adr,
    input  logic [DW-1:0] c_din,
    output logic          c_gnt,
    input  logic          l_req,
    input  logic          l_lock,
    input  logic          l_we,
    input  logic [AW-1:0] l_adr,
    input  logic [DW-1:0] l_din,
    output logic          l_gnt,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          rd_owner,
    output logic [AW-1:0] MemAdr,
    output logic          MemReadEn,
    output logic          MemWriteEn,
    output logic [DW-1:0] MemDatIn,
    input  logic [DW-1:0] MemDatOut
);
    localparam int              CW      = $clog2(MAXBURST + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(MAXBURST);

    typedef enum logic {SHARED = 1'b0, LOCKED = 1'b1} state_t;

    state_t          r_st;
    logic            r_last;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_rd_data;
    logic            r_rd_valid;
    logic            r_rd_owner;

    logic            w_force;
    logic            w_c_gnt;
    logic            w_l_gnt;

    // Grant decision; r_last=1 means the loader won last, so the core wins a tie.
    always_comb begin
        w_force = 1'b0;
        w_c_gnt = 1'b0;
        w_l_gnt = 1'b0;
        if (reset) begin
            w_force = 1'b0;
        end else begin
            case (r_st)
                LOCKED: begin
                    w_force = (r_cnt == CNT_MAX) && c_req;
                    w_c_gnt = w_force;
                    w_l_gnt = l_req && !w_force;
                end
                SHARED: begin
                    w_c_gnt = c_req && (!l_req || r_last);
                    w_l_gnt = l_req && (!c_req || !r_last);
                end
                default: begin
                    w_c_gnt = 1'b0;
                    w_l_gnt = 1'b0;
                end
            endcase
        end
    end

    // Memory port mux driven from the winner; idle port is fully zeroed.
    always_comb begin
        MemAdr     = {AW{1'b0}};
        MemDatIn   = {DW{1'b0}};
        MemWriteEn = 1'b0;
        MemReadEn  = 1'b0;
        if (w_c_gnt) begin
            MemAdr     = c_adr;
            MemDatIn   = c_din;
            MemWriteEn = c_we;
            MemReadEn  = !c_we;
        end else if (w_l_gnt) begin
            MemAdr     = l_adr;
            MemDatIn   = l_din;
            MemWriteEn = l_we;
            MemReadEn  = !l_we;
        end else begin
            MemAdr     = {AW{1'b0}};
        end
    end

    // Arbitration state, burst counter and registered read return.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_st       <= SHARED;
            r_last     <= 1'b1;
            r_cnt      <= {CW{1'b0}};
            r_rd_data  <= {DW{1'b0}};
            r_rd_valid <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            if (w_c_gnt || w_l_gnt) begin
                r_last <= w_l_gnt;
            end
            case (r_st)
                SHARED: begin
                    if (w_l_gnt && l_lock) begin
                        r_st  <= LOCKED;
                        r_cnt <= CW'(1);
                    end else begin
                        r_cnt <= {CW{1'b0}};
                    end
                end
                LOCKED: begin
                    if (w_force || !l_lock) begin
                        r_st  <= SHARED;
                        r_cnt <= {CW{1'b0}};
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CW'(1);
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                default: begin
                    r_st  <= SHARED;
                    r_cnt <= {CW{1'b0}};
                end
            endcase
            r_rd_valid <= MemReadEn;
            if (MemReadEn) begin
                r_rd_data  <= MemDatOut;
                r_rd_owner <= w_l_gnt;
            end
        end
    end

    assign c_gnt    = w_c_gnt;
    assign l_gnt    = w_l_gnt;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign rd_owner = r_rd_owner;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: a driver predicts each cycle from an abstract model,
// a monitor compares grants, memory drive and read returns as the DUT presents them.
module tb_dm_arbiter;
    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       reset, c_req, c_we, l_req, l_lock, l_we;
    logic [7:0] c_adr, c_din, l_adr, l_din;
    logic       c_gnt, l_gnt, rd_valid, rd_owner, MemReadEn, MemWriteEn;
    logic [7:0] rd_data, MemAdr, MemDatIn, MemDatOut;

    logic [7:0] dm      [256];
    logic [7:0] ref_mem [256];

    typedef struct {
        logic       cg, lg, re, we;
        logic [7:0] adr, din;
        int         cyc;
    } exp_t;
    typedef struct {
        logic [7:0] data;
        logic       owner;
        int         due;
    } rd_t;

    exp_t gq[$];
    rd_t  rq[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    bit   m_locked = 1'b0;
    bit   m_last_loader = 1'b1;
    int   m_cnt = 0;
    bit   m_gc, m_gl;

    dm_arbiter #(.AW(8), .DW(8), .MAXBURST(MB)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_din(c_din), .c_gnt(c_gnt),
        .l_req(l_req), .l_lock(l_lock), .l_we(l_we), .l_adr(l_adr), .l_din(l_din), .l_gnt(l_gnt),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_owner(rd_owner),
        .MemAdr(MemAdr), .MemReadEn(MemReadEn), .MemWriteEn(MemWriteEn),
        .MemDatIn(MemDatIn), .MemDatOut(MemDatOut)
    );

    always #5 clk = ~clk;

    assign MemDatOut = dm[MemAdr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle and predict it: grants, memory drive and any read return.
    task automatic drv(input bit rst, input bit cr, input bit cwe, input logic [7:0] ca,
                       input logic [7:0] cd, input bit lr, input bit ll, input bit lwe,
                       input logic [7:0] la, input logic [7:0] ld);
        exp_t e;
        rd_t  r;
        bit   gc, gl, force_rel;
        @(negedge clk);
        reset = rst; c_req = cr; c_we = cwe; c_adr = ca; c_din = cd;
        l_req = lr; l_lock = ll; l_we = lwe; l_adr = la; l_din = ld;
        force_rel = 1'b0;
        if (rst) begin
            gc = 1'b0; gl = 1'b0;
        end else if (m_locked) begin
            force_rel = (m_cnt == MB) && cr;
            gc = force_rel;
            gl = lr && !force_rel;
        end else if (cr && lr) begin
            gc = m_last_loader;
            gl = !m_last_loader;
        end else begin
            gc = cr; gl = lr;
        end
        e.cg = gc; e.lg = gl; e.cyc = cyc;
        e.adr = gc ? ca : (gl ? la : 8'h00);
        e.din = gc ? cd : (gl ? ld : 8'h00);
        e.we  = (gc && cwe) || (gl && lwe);
        e.re  = (gc && !cwe) || (gl && !lwe);
        gq.push_back(e);
        if (e.re) begin
            r.data = ref_mem[e.adr]; r.owner = gl; r.due = cyc + 1;
            rq.push_back(r);
        end
        if (e.we) ref_mem[e.adr] = e.din;
        if (rst) begin
            m_locked = 1'b0; m_last_loader = 1'b1; m_cnt = 0;
        end else begin
            if (gc || gl) m_last_loader = gl;
            if (m_locked) begin
                if (force_rel || !ll) begin
                    m_locked = 1'b0; m_cnt = 0;
                end else begin
                    m_cnt = (m_cnt < MB) ? m_cnt + 1 : MB;
                end
            end else if (gl && ll) begin
                m_locked = 1'b1; m_cnt = 1;
            end
        end
        m_gc = gc; m_gl = gl;
        cyc++;
    endtask

    // Monitor: sample just before each rising edge and compare against the queues.
    always begin
        exp_t e;
        bit   exp_v;
        @(negedge clk);
        #4;
        if (gq.size() > 0) begin
            e = gq.pop_front();
            chk("c_gnt", c_gnt, e.cg);
            chk("l_gnt", l_gnt, e.lg);
            chk("MemReadEn", MemReadEn, e.re);
            chk("MemWriteEn", MemWriteEn, e.we);
            chk("MemAdr", MemAdr, e.adr);
            chk("MemDatIn", MemDatIn, e.din);
            chk("en_exclusive", MemReadEn && MemWriteEn, 1'b0);
            exp_v = (rq.size() > 0) && (rq[0].due == e.cyc);
            chk("rd_valid", rd_valid, exp_v);
            if (exp_v) begin
                if (rd_valid) begin
                    chk("rd_data", rd_data, rq[0].data);
                    chk("rd_owner", rd_owner, rq[0].owner);
                end
                void'(rq.pop_front());
            end
        end
    end

    initial begin
        bit         hc_req, hc_we, hl_req, hl_lock, hl_we, rst;
        logic [7:0] hc_adr, hc_din, hl_adr, hl_din, v;
        int         dens;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            dm[i] = v;
            ref_mem[i] = v;
        end
        dm[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
        reset = 1'b1; c_req = 1'b0; c_we = 1'b0; c_adr = 8'h00; c_din = 8'h00;
        l_req = 1'b0; l_lock = 1'b0; l_we = 1'b0; l_adr = 8'h00; l_din = 8'h00;
        fork
            forever begin
                @(posedge clk);
                if (MemWriteEn) dm[MemAdr] <= MemDatIn;
            end
        join_none

        drv(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drv(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        #3;
        chk("reset_rd_data", rd_data, 8'h00);
        chk("reset_rd_owner", rd_owner, 1'b0);
        chk("reset_rd_valid", rd_valid, 1'b0);

        // Core read of the preloaded location right after reset
        drv(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drv(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        // Both requesting without lock: strict alternation
        drv(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (6) drv(1'b0, 1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0, 1'b0, 8'h31, 8'h00);

        // Loader burst with the core waiting from cycle 1: force release at cycle 4
        drv(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drv(1'b0, 1'b0, 1'b0, 8'h41, 8'h00, 1'b1, 1'b1, 1'b0, 8'h40, 8'h00);
        repeat (7) drv(1'b0, 1'b1, 1'b0, 8'h41, 8'h00, 1'b1, 1'b1, 1'b0, 8'h40, 8'h00);

        // Long lock with an idle core, then release and a tie the core must win
        drv(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (20) drv(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h50, 8'h00);
        drv(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h51, 8'h00);
        repeat (2) drv(1'b0, 1'b1, 1'b0, 8'h52, 8'h00, 1'b1, 1'b0, 1'b0, 8'h53, 8'h00);

        // Loader write then core read of the same address
        drv(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drv(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h20, 8'h3C);
        drv(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drv(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        // Reset in the middle of a locked burst
        drv(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drv(1'b0, 1'b0, 1'b0, 8'h60, 8'h00, 1'b1, 1'b1, 1'b1, 8'h61, 8'h77);
        repeat (2) drv(1'b0, 1'b1, 1'b1, 8'h60, 8'h11, 1'b1, 1'b1, 1'b1, 8'h61, 8'h77);
        repeat (2) drv(1'b1, 1'b1, 1'b1, 8'h60, 8'h11, 1'b1, 1'b1, 1'b1, 8'h61, 8'h77);
        repeat (3) drv(1'b0, 1'b1, 1'b0, 8'h60, 8'h00, 1'b1, 1'b0, 1'b0, 8'h61, 8'h00);

        // Randomized traffic obeying the hold-until-grant protocol
        hc_req = 1'b0; hc_we = 1'b0; hc_adr = 8'h00; hc_din = 8'h00;
        hl_req = 1'b0; hl_lock = 1'b0; hl_we = 1'b0; hl_adr = 8'h00; hl_din = 8'h00;
        m_gc = 1'b1; m_gl = 1'b1;
        dens = 2;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) dens = int'($urandom_range(1, 4));
            if (!hc_req || m_gc) begin
                hc_req = ($urandom_range(0, 4) < dens);
                hc_we  = 1'($urandom);
                hc_adr = 8'($urandom_range(0, 31));
                hc_din = 8'($urandom);
            end
            if (!hl_req || m_gl) begin
                hl_req = ($urandom_range(0, 4) < dens);
                hl_we  = 1'($urandom);
                hl_adr = 8'($urandom_range(0, 31));
                hl_din = 8'($urandom);
            end
            if (hl_lock) hl_lock = ($urandom_range(0, 15) != 0);
            else         hl_lock = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 299) == 0);
            drv(rst, hc_req, hc_we, hc_adr, hc_din, hl_req, hl_lock, hl_we, hl_adr, hl_din);
        end

        repeat (3) drv(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        #6;
        chk("grant_queue_drained", gq.size(), 0);
        chk("read_queue_drained", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
